// File: rtl/cfs_tx_ctrl_skid_if.sv
// Handshake bundle between the TX FIFO pop port and the MD TX interface.
// The slave modport is the controller's view; master is the surrounding environment.
interface cfs_tx_ctrl_skid_if #(
    parameter int ALGN_DATA_WIDTH = 32
);
    localparam int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8);
    localparam int ALGN_SIZE_WIDTH   = $clog2(ALGN_DATA_WIDTH / 8) + 1;
    localparam int FIFO_DATA_WIDTH   = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH;

    logic                         pop_valid;
    logic [FIFO_DATA_WIDTH-1:0]   pop_data;
    logic                         pop_ready;
    logic                         md_tx_valid;
    logic [ALGN_DATA_WIDTH-1:0]   md_tx_data;
    logic [ALGN_OFFSET_WIDTH-1:0] md_tx_offset;
    logic [ALGN_SIZE_WIDTH-1:0]   md_tx_size;
    logic                         md_tx_ready;

    modport slave (
        input  pop_valid,
        input  pop_data,
        input  md_tx_ready,
        output pop_ready,
        output md_tx_valid,
        output md_tx_data,
        output md_tx_offset,
        output md_tx_size
    );

    modport master (
        output pop_valid,
        output pop_data,
        output md_tx_ready,
        input  pop_ready,
        input  md_tx_valid,
        input  md_tx_data,
        input  md_tx_offset,
        input  md_tx_size
    );
endinterface

// File: rtl/cfs_tx_ctrl_skid.sv
// Registered TX controller: 2-entry skid buffer between FIFO pop and MD TX,
// zero-size entry dropping, back-pressure stall flag and transfer counter.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | no entry held, md_tx_valid low
// ST_ONE   | main register holds the head entry
// ST_TWO   | main holds head, skid holds next; pop_ready low
module cfs_tx_ctrl_skid #(
    parameter int ALGN_DATA_WIDTH = 32,
    parameter int STALL_THRESHOLD = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clr_cnt_i,
    cfs_tx_ctrl_skid_if.slave    bus_if,
    output logic                 md_tx_stall_o,
    output logic                 drop_pulse_o,
    output logic [CNT_WIDTH-1:0] tx_cnt_o
);
    localparam int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8);
    localparam int ALGN_SIZE_WIDTH   = $clog2(ALGN_DATA_WIDTH / 8) + 1;
    localparam int FIFO_DATA_WIDTH   = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH;
    localparam int STALL_CNT_WIDTH   = $clog2(STALL_THRESHOLD + 1);
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = STALL_CNT_WIDTH'(STALL_THRESHOLD);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [FIFO_DATA_WIDTH-1:0]   main_q, main_d;
    logic [FIFO_DATA_WIDTH-1:0]   skid_q, skid_d;
    logic                         pop_ready_q, pop_ready_d;
    logic                         drop_q, drop_d;
    logic [STALL_CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
    logic                         stall_q, stall_d;
    logic [CNT_WIDTH-1:0]         tx_cnt_q, tx_cnt_d;

    logic                         out_valid;
    logic                         push;
    logic                         pop;
    logic                         push_zero;
    logic                         push_store;
    logic [ALGN_SIZE_WIDTH-1:0]   push_size;

    assign out_valid  = (state_q != ST_EMPTY);
    assign push_size  = bus_if.pop_data[FIFO_DATA_WIDTH-1 -: ALGN_SIZE_WIDTH];
    assign push       = bus_if.pop_valid & pop_ready_q;
    assign pop        = out_valid & bus_if.md_tx_ready;
    assign push_zero  = push & (push_size == '0);
    assign push_store = push & ~push_zero;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            pop_ready_q <= 1'b0;
            drop_q      <= 1'b0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
            tx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            pop_ready_q <= pop_ready_d;
            drop_q      <= drop_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

    // Zero-size pushes never reach the storage, so only push_store moves the FSM.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push_store) begin
                    state_d = ST_ONE;
                    main_d  = bus_if.pop_data;
                end
            end
            ST_ONE: begin
                if (push_store && pop) begin
                    main_d = bus_if.pop_data;
                end else if (push_store) begin
                    state_d = ST_TWO;
                    skid_d  = bus_if.pop_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // pop_ready looks at the next occupancy only, keeping md_tx_ready off the pop path.
    always_comb begin
        pop_ready_d = (state_d != ST_TWO);
        drop_d      = push_zero;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!out_valid || pop) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        stall_d = (stall_cnt_d == STALL_MAX);
    end

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (clr_cnt_i) begin
            tx_cnt_d = '0;
        end else if (pop) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end
    end

    assign bus_if.pop_ready    = pop_ready_q;
    assign bus_if.md_tx_valid  = out_valid;
    assign bus_if.md_tx_data   = main_q[ALGN_DATA_WIDTH-1:0];
    assign bus_if.md_tx_offset = main_q[ALGN_DATA_WIDTH +: ALGN_OFFSET_WIDTH];
    assign bus_if.md_tx_size   = main_q[ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH +: ALGN_SIZE_WIDTH];
    assign md_tx_stall_o       = stall_q;
    assign drop_pulse_o        = drop_q;
    assign tx_cnt_o            = tx_cnt_q;
endmodule

// File: tb/tb_cfs_tx_ctrl_skid.sv
// Self-checking bench for cfs_tx_ctrl_skid: directed vector table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_cfs_tx_ctrl_skid;
    localparam int DW = 32;
    localparam int OW = 2;
    localparam int SW = 3;
    localparam int FW = DW + OW + SW;
    localparam int TH = 16;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          clr_cnt;
    logic          md_tx_stall;
    logic          drop_pulse;
    logic [CW-1:0] tx_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    cfs_tx_ctrl_skid_if #(.ALGN_DATA_WIDTH(DW)) bus_if ();

    cfs_tx_ctrl_skid #(
        .ALGN_DATA_WIDTH(DW),
        .STALL_THRESHOLD(TH),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .clr_cnt_i    (clr_cnt),
        .bus_if       (bus_if),
        .md_tx_stall_o(md_tx_stall),
        .drop_pulse_o (drop_pulse),
        .tx_cnt_o     (tx_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of held entries plus flag/counter state.
    logic [FW-1:0] mq[$];
    bit            m_pr;
    bit            m_drop;
    int            m_sc;
    int            m_cnt;

    typedef struct {
        bit          pv;
        logic [2:0]  size;
        logic [1:0]  off;
        logic [31:0] data;
        bit          rdy;
        bit          exp_valid;
        logic [2:0]  exp_size;
        logic [1:0]  exp_off;
        logic [31:0] exp_data;
        bit          exp_pr;
        bit          exp_drop;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [FW-1:0] ent(logic [2:0] s, logic [1:0] o, logic [31:0] d);
        return {s, o, d};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pr   = 1'b0;
        m_drop = 1'b0;
        m_sc   = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        bit            v;
        bit            pop;
        bit            push;
        logic [FW-1:0] pd;
        v    = (mq.size() > 0);
        pop  = v && bus_if.md_tx_ready;
        push = bus_if.pop_valid && m_pr;
        pd   = bus_if.pop_data;
        if (!v || pop) m_sc = 0;
        else if (m_sc < TH) m_sc++;
        if (pop) void'(mq.pop_front());
        if (push && pd[FW-1 -: SW] != 0) mq.push_back(pd);
        m_drop = push && (pd[FW-1 -: SW] == 0);
        m_pr   = (mq.size() < 2);
        if (clr_cnt) m_cnt = 0;
        else if (pop) m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    task automatic drive(bit pv, logic [FW-1:0] pd, bit rdy, bit clr);
        bus_if.pop_valid   = pv;
        bus_if.pop_data    = pd;
        bus_if.md_tx_ready = rdy;
        clr_cnt            = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model();
        chk("valid", bus_if.md_tx_valid, (mq.size() > 0));
        chk("pop_ready", bus_if.pop_ready, m_pr);
        chk("drop", drop_pulse, m_drop);
        chk("stall", md_tx_stall, (m_sc == TH));
        chk("tx_cnt", tx_cnt, m_cnt);
        if (mq.size() > 0) begin
            chk("data", bus_if.md_tx_data, mq[0][DW-1:0]);
            chk("offset", bus_if.md_tx_offset, mq[0][DW +: OW]);
            chk("size", bus_if.md_tx_size, mq[0][DW+OW +: SW]);
        end
    endtask

    initial begin
        int pushes;
        int pops;
        int cycles;
        bit seen17;

        tbl[0]  = '{1, 3'd1, 2'd0, 32'hA000_0001, 0, 0, 3'd0, 2'd0, 32'h0,          1, 0, 1};
        tbl[1]  = '{1, 3'd2, 2'd1, 32'hB000_0002, 0, 1, 3'd1, 2'd0, 32'hA000_0001, 1, 0, 1};
        tbl[2]  = '{1, 3'd3, 2'd2, 32'hC000_0003, 0, 1, 3'd1, 2'd0, 32'hA000_0001, 0, 0, 1};
        tbl[3]  = '{1, 3'd3, 2'd2, 32'hC000_0003, 1, 1, 3'd1, 2'd0, 32'hA000_0001, 0, 0, 1};
        tbl[4]  = '{1, 3'd3, 2'd2, 32'hC000_0003, 1, 1, 3'd2, 2'd1, 32'hB000_0002, 1, 0, 2};
        tbl[5]  = '{0, 3'd0, 2'd0, 32'h0,          1, 1, 3'd3, 2'd2, 32'hC000_0003, 1, 0, 3};
        tbl[6]  = '{1, 3'd2, 2'd3, 32'hD000_0004, 1, 0, 3'd0, 2'd0, 32'h0,          1, 0, 4};
        tbl[7]  = '{1, 3'd0, 2'd0, 32'h0BAD_0BAD, 1, 1, 3'd2, 2'd3, 32'hD000_0004, 1, 0, 4};
        tbl[8]  = '{1, 3'd1, 2'd0, 32'hE000_0005, 1, 0, 3'd0, 2'd0, 32'h0,          1, 1, 5};
        tbl[9]  = '{0, 3'd0, 2'd0, 32'h0,          1, 1, 3'd1, 2'd0, 32'hE000_0005, 1, 0, 5};
        tbl[10] = '{0, 3'd0, 2'd0, 32'h0,          1, 0, 3'd0, 2'd0, 32'h0,          1, 0, 6};

        rst = 1'b1;
        drive(0, '0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus_if.md_tx_valid, 0);
        chk("rst_pop_ready", bus_if.pop_ready, 0);
        chk("rst_cnt", tx_cnt, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_stall", md_tx_stall, 0);
        rst = 1'b0;

        // Reset release and first-transfer latency
        drive(1, ent(3'd4, 2'd0, 32'hDEAD_BEEF), 1, 0);
        chk("lat_pr_r0", bus_if.pop_ready, 0);
        tick();
        chk("lat_pr_r1", bus_if.pop_ready, 1);
        chk("lat_valid_r1", bus_if.md_tx_valid, 0);
        tick();
        drive(0, '0, 1, 0);
        chk("lat_valid_r2", bus_if.md_tx_valid, 1);
        chk("lat_data_r2", bus_if.md_tx_data, 32'hDEAD_BEEF);
        chk("lat_size_r2", bus_if.md_tx_size, 4);
        tick();
        chk("lat_cnt_r3", tx_cnt, 1);
        chk("lat_valid_r3", bus_if.md_tx_valid, 0);
        tick();

        // Back-pressure fill, release and zero-size drop
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].pv, ent(tbl[i].size, tbl[i].off, tbl[i].data), tbl[i].rdy, 0);
            chk($sformatf("tbl%0d_valid", i), bus_if.md_tx_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_pop_ready", i), bus_if.pop_ready, tbl[i].exp_pr);
            chk($sformatf("tbl%0d_drop", i), drop_pulse, tbl[i].exp_drop);
            chk($sformatf("tbl%0d_cnt", i), tx_cnt, tbl[i].exp_cnt);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_size", i), bus_if.md_tx_size, tbl[i].exp_size);
                chk($sformatf("tbl%0d_off", i), bus_if.md_tx_offset, tbl[i].exp_off);
                chk($sformatf("tbl%0d_data", i), bus_if.md_tx_data, tbl[i].exp_data);
            end
            tick();
        end

        // Stall flag: set once 16 stalled cycles have completed, cleared after the pop
        drive(1, ent(3'd4, 2'd1, 32'hF000_0006), 0, 0);
        tick();
        for (int k = 1; k <= 20; k++) begin
            drive(0, '0, 0, 0);
            chk($sformatf("stall_k%0d", k), md_tx_stall, (k >= 17));
            chk($sformatf("stall_hold_k%0d", k), bus_if.md_tx_data, 32'hF000_0006);
            tick();
        end
        drive(0, '0, 1, 0);
        chk("stall_at_pop", md_tx_stall, 1);
        tick();
        chk("stall_after_pop", md_tx_stall, 0);
        chk("stall_cnt", tx_cnt, 7);

        // Async reset while in TWO
        drive(1, ent(3'd1, 2'd0, 32'h1111_0001), 0, 0);
        tick();
        drive(1, ent(3'd2, 2'd0, 32'h1111_0002), 0, 0);
        tick();
        drive(0, '0, 0, 0);
        chk("two_pop_ready", bus_if.pop_ready, 0);
        chk("two_valid", bus_if.md_tx_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", bus_if.md_tx_valid, 0);
        chk("arst_pop_ready", bus_if.pop_ready, 0);
        chk("arst_drop", drop_pulse, 0);
        chk("arst_cnt", tx_cnt, 0);
        chk("arst_data", bus_if.md_tx_data, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive(0, '0, 1, 0);
        check_model();
        tick();
        check_model();

        // Streaming 100 entries with ready held high; counter wraps at 16
        pushes = 0;
        pops   = 0;
        cycles = 0;
        seen17 = 0;
        while (pushes < 100 && cycles < 300) begin
            drive(1, ent(3'($urandom_range(1, 7)), 2'($urandom), $urandom), 1, 0);
            check_model();
            if (bus_if.pop_ready) pushes++;
            if (bus_if.md_tx_valid) pops++;
            tick();
            cycles++;
            if (pops == 17 && !seen17) begin
                seen17 = 1;
                chk("wrap17_cnt", tx_cnt, 1);
            end
        end
        for (int d = 0; d < 5 && bus_if.md_tx_valid; d++) begin
            drive(0, '0, 1, 0);
            check_model();
            pops++;
            tick();
        end
        chk("stream_cycles", cycles, 100);
        chk("stream_pops", pops, 100);
        chk("stream_cnt", tx_cnt, 100 % 16);
        chk("stream_empty", bus_if.md_tx_valid, 0);

        // clr_cnt coincident with a pop: clear wins
        drive(1, ent(3'd1, 2'd0, 32'h2222_0001), 1, 0);
        tick();
        drive(0, '0, 1, 1);
        chk("clr_valid", bus_if.md_tx_valid, 1);
        tick();
        drive(0, '0, 1, 0);
        chk("clr_cnt", tx_cnt, 0);
        tick();

        // Random traffic against the model
        for (int c = 0; c < 500; c++) begin
            drive(($urandom_range(0, 3) != 0),
                  ent(($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
                      2'($urandom), $urandom),
                  ($urandom_range(0, 2) != 0) || (c % 64 < 8 ? 1'b0 : 1'b0),
                  ($urandom_range(0, 15) == 0));
            if (c % 97 > 70) bus_if.md_tx_ready = 1'b0;
            check_model();
            tick();
        end
        drive(0, '0, 1, 0);
        for (int d = 0; d < 4; d++) begin
            check_model();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
